// File: rtl/mips_muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: operation codes,
// FSM states and the divide-by-zero quotient constant.
package mips_muldiv_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    MD_NOP   = 3'b000,
    MD_MULT  = 3'b001,
    MD_MULTU = 3'b010,
    MD_DIV   = 3'b011,
    MD_DIVU  = 3'b100,
    MD_MTHI  = 3'b101,
    MD_MTLO  = 3'b110
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_e;

  localparam logic [DATA_W-1:0] DIVZERO_LO = '1;

  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mips_muldiv_step.sv
// One radix-2 iteration on the {hi,lo} working pair: shift-add for multiply,
// restoring shift-subtract for divide (quotient bits enter lo from the right).
module mips_muldiv_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_is_div,
  input  logic [DATA_WIDTH-1:0] i_hi,
  input  logic [DATA_WIDTH-1:0] i_lo,
  input  logic [DATA_WIDTH-1:0] i_m,
  output logic [DATA_WIDTH-1:0] o_hi,
  output logic [DATA_WIDTH-1:0] o_lo
);

  logic [DATA_WIDTH:0] w_sum;
  logic [DATA_WIDTH:0] w_sh;

  assign w_sum = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_m} : '0);
  assign w_sh  = {i_hi, i_lo[DATA_WIDTH-1]};

  // The partial remainder is always below the divisor, so the low bits of the
  // subtraction hold the full result whenever the trial succeeds.
  always_comb begin
    o_hi = w_sum[DATA_WIDTH:1];
    o_lo = {w_sum[0], i_lo[DATA_WIDTH-1:1]};
    if (i_is_div) begin
      if (w_sh >= {1'b0, i_m}) begin
        o_hi = w_sh[DATA_WIDTH-1:0] - i_m;
        o_lo = {i_lo[DATA_WIDTH-2:0], 1'b1};
      end else begin
        o_hi = w_sh[DATA_WIDTH-1:0];
        o_lo = {i_lo[DATA_WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mips_muldiv.sv
// Execute-stage multiply/divide unit owning HI/LO. Operates on magnitudes for
// DATA_WIDTH iterations, then applies signs in a single FIX cycle.
module mips_muldiv
  import mips_muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            MDControl,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic [DATA_WIDTH-1:0] Hi,
  output logic [DATA_WIDTH-1:0] Lo,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  state_e                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [DATA_WIDTH-1:0]   r_hi, r_lo, r_acc_hi, r_acc_lo, r_m;
  logic                    r_is_div, r_neg_res, r_neg_rem, r_div0, r_busy, r_done;

  logic                    w_sign_op, w_div_op, w_neg_a, w_neg_b;
  logic [DATA_WIDTH-1:0]   w_mag_a, w_mag_b, w_step_hi, w_step_lo, w_quot, w_rem;
  logic [2*DATA_WIDTH-1:0] w_prod;

  assign w_sign_op = (MDControl == MD_MULT) || (MDControl == MD_DIV);
  assign w_div_op  = (MDControl == MD_DIV) || (MDControl == MD_DIVU);
  assign w_neg_a   = w_sign_op & SrcA[DATA_WIDTH-1];
  assign w_neg_b   = w_sign_op & SrcB[DATA_WIDTH-1];
  assign w_mag_a   = w_neg_a ? -SrcA : SrcA;
  assign w_mag_b   = w_neg_b ? -SrcB : SrcB;

  mips_muldiv_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .i_is_div (r_is_div),
    .i_hi     (r_acc_hi),
    .i_lo     (r_acc_lo),
    .i_m      (r_m),
    .o_hi     (w_step_hi),
    .o_lo     (w_step_lo)
  );

  // Divide by zero leaves |dividend| in the remainder, so the sign fix restores SrcA.
  assign w_prod = r_neg_res ? -{r_acc_hi, r_acc_lo} : {r_acc_hi, r_acc_lo};
  assign w_quot = r_div0 ? DATA_WIDTH'(DIVZERO_LO) : (r_neg_res ? -r_acc_lo : r_acc_lo);
  assign w_rem  = r_neg_rem ? -r_acc_hi : r_acc_hi;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_acc_hi  <= '0;
      r_acc_lo  <= '0;
      r_m       <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_div0    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (MDControl == MD_MTHI) begin
              r_hi <= SrcA;
            end else if (MDControl == MD_MTLO) begin
              r_lo <= SrcA;
            end else if (is_muldiv(MDControl)) begin
              r_acc_hi  <= '0;
              r_acc_lo  <= w_mag_a;
              r_m       <= w_mag_b;
              r_is_div  <= w_div_op;
              r_neg_res <= w_neg_a ^ w_neg_b;
              r_neg_rem <= w_neg_a;
              r_div0    <= w_div_op && (SrcB == '0);
              r_cnt     <= '0;
              r_busy    <= 1'b1;
              r_state   <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_acc_hi <= w_step_hi;
          r_acc_lo <= w_step_lo;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(DATA_WIDTH - 1)) r_state <= S_FIX;
        end
        S_FIX: begin
          if (r_is_div) begin
            r_hi <= w_rem;
            r_lo <= w_quot;
          end else begin
            {r_hi, r_lo} <= w_prod;
          end
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Hi   = r_hi;
  assign Lo   = r_lo;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_mips_muldiv.sv
// Bench for mips_muldiv: directed cases plus random mul/div ops checked
// against a 64-bit arithmetic reference model.
module tb_mips_muldiv;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;
  localparam logic [2:0] OP_RSVD  = 3'b111;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  MDControl;
  logic [31:0] SrcA, SrcB;
  logic [31:0] Hi, Lo;
  logic        busy, done;

  int total = 0;
  int bad   = 0;

  mips_muldiv #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .MDControl (MDControl),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .Hi        (Hi),
    .Lo        (Lo),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Reference: returns {HI, LO} from plain integer arithmetic.
  function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int     sa, sb;
    longint p;
    sa = a;
    sb = b;
    case (op)
      OP_MULT: begin
        p = longint'(sa) * longint'(sb);
        return 64'(p);
      end
      OP_MULTU: return {32'b0, a} * {32'b0, b};
      OP_DIV: begin
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      OP_DIVU: begin
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
      default: return 64'h0;
    endcase
  endfunction

  // Issues one op at the current negedge and follows it to done, recording
  // latency, busy gaps and any HI/LO movement before done. Optionally fires
  // MTHI and DIVU starts while busy; operands are scrambled during flight.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit inject, output int lat, output int busy_bad,
                        output int hold_bad, output logic [31:0] hi, output logic [31:0] lo);
    logic [31:0] hi0, lo0;
    hi0 = Hi; lo0 = Lo;
    lat = -1; busy_bad = 0; hold_bad = 0;
    start = 1'b1; MDControl = op; SrcA = a; SrcB = b;
    @(negedge clk);
    start = 1'b0; MDControl = OP_NOP;
    for (int k = 1; k <= 40; k++) begin
      SrcA = $urandom; SrcB = $urandom;
      if (inject && k == 5) begin start = 1'b1; MDControl = OP_MTHI; end
      else if (inject && k == 6) begin start = 1'b1; MDControl = OP_DIVU; SrcB = 32'd3; end
      else begin start = 1'b0; MDControl = OP_NOP; end
      if (done) begin lat = k; break; end
      if (busy !== 1'b1) busy_bad++;
      if (Hi !== hi0 || Lo !== lo0) hold_bad++;
      @(negedge clk);
    end
    start = 1'b0; MDControl = OP_NOP;
    hi = Hi; lo = Lo;
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h lat=%0d", op, a, b, hi, lo, lat);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; MDControl = OP_NOP; SrcA = '0; SrcB = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if (Hi !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h want=0", Hi); end
    total++; if (Lo !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h want=0", Lo); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    $display("reset checked hi=%h lo=%h busy=%b done=%b", Hi, Lo, busy, done);
  endtask

  task automatic test_directed(input string name, input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] want_hi, input logic [31:0] want_lo);
    int lat, bb, hb;
    logic [31:0] hi, lo;
    run_op(op, a, b, 1'b0, lat, bb, hb, hi, lo);
    total++; if (lat !== 34) begin bad++; $display("FAIL %s_latency got=%0d want=34", name, lat); end
    total++; if (bb !== 0) begin bad++; $display("FAIL %s_busy_window low_cycles=%0d want=0", name, bb); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s_busy_at_done got=%b want=0", name, busy); end
    total++; if (hb !== 0) begin bad++; $display("FAIL %s_hilo_hold changed_cycles=%0d want=0", name, hb); end
    total++; if (hi !== want_hi) begin bad++; $display("FAIL %s_hi got=%h want=%h", name, hi, want_hi); end
    total++; if (lo !== want_lo) begin bad++; $display("FAIL %s_lo got=%h want=%h", name, lo, want_lo); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL %s_done_pulse got=%b want=0", name, done); end
  endtask

  task automatic test_mul();
    test_directed("mult_neg",  OP_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA);
    test_directed("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    test_directed("mult_min",  OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
  endtask

  task automatic test_div();
    test_directed("div_neg",   OP_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
    test_directed("divu",      OP_DIVU, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E);
    test_directed("div_zero",  OP_DIV,  32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF);
    test_directed("div_zneg",  OP_DIV,  32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF);
    test_directed("divu_zero", OP_DIVU, 32'h80000000, 32'h00000000, 32'h80000000, 32'hFFFFFFFF);
    test_directed("div_ovf",   OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
  endtask

  task automatic test_mthilo();
    logic [31:0] hi0, lo0;
    hi0 = Hi;
    start = 1'b1; MDControl = OP_MTLO; SrcA = 32'hA5A5A5A5;
    @(negedge clk);
    start = 1'b0; MDControl = OP_NOP;
    total++; if (Lo !== 32'hA5A5A5A5) begin bad++; $display("FAIL mtlo_lo got=%h want=a5a5a5a5", Lo); end
    total++; if (Hi !== hi0) begin bad++; $display("FAIL mtlo_hi got=%h want=%h", Hi, hi0); end
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mtlo_flags got=%b%b want=00", done, busy); end
    $display("mtlo a5a5a5a5 -> lo=%h", Lo);
    start = 1'b1; MDControl = OP_MTHI; SrcA = 32'h5A5A1234;
    @(negedge clk);
    start = 1'b0; MDControl = OP_NOP;
    total++; if (Hi !== 32'h5A5A1234) begin bad++; $display("FAIL mthi_hi got=%h want=5a5a1234", Hi); end
    total++; if (Lo !== 32'hA5A5A5A5) begin bad++; $display("FAIL mthi_lo got=%h want=a5a5a5a5", Lo); end
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mthi_flags got=%b%b want=00", done, busy); end
    $display("mthi 5a5a1234 -> hi=%h", Hi);
    hi0 = Hi; lo0 = Lo;
    start = 1'b1; MDControl = OP_RSVD; SrcA = 32'hDEADBEEF; SrcB = 32'h00000005;
    @(negedge clk);
    start = 1'b0; MDControl = OP_NOP;
    total++; if (Hi !== hi0 || Lo !== lo0 || busy !== 1'b0) begin
      bad++; $display("FAIL reserved_nop got=%h/%h/%b want=%h/%h/0", Hi, Lo, busy, hi0, lo0);
    end
    $display("reserved op -> hi=%h lo=%h busy=%b", Hi, Lo, busy);
  endtask

  task automatic test_busy_ignore();
    int lat, bb, hb, extra_busy;
    logic [31:0] hi, lo;
    logic [63:0] exp;
    exp = ref_model(OP_DIVU, 32'd1000, 32'd7);
    run_op(OP_DIVU, 32'd1000, 32'd7, 1'b1, lat, bb, hb, hi, lo);
    total++; if (lat !== 34) begin bad++; $display("FAIL ignore_latency got=%0d want=34", lat); end
    total++; if (hb !== 0) begin bad++; $display("FAIL ignore_hold changed_cycles=%0d want=0", hb); end
    total++; if ({hi, lo} !== exp) begin bad++; $display("FAIL ignore_result got=%h want=%h", {hi, lo}, exp); end
    extra_busy = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) extra_busy++;
    end
    total++; if (extra_busy !== 0) begin bad++; $display("FAIL ignore_no_second_op active_cycles=%0d want=0", extra_busy); end
    $display("busy-ignore divu 1000/7 -> hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, bb, hb;
    logic [31:0] hi1, lo1, hi2, lo2;
    logic [63:0] e1, e2;
    e1 = ref_model(OP_MULTU, 32'h12345678, 32'h9ABCDEF0);
    e2 = ref_model(OP_DIV, 32'hF0000001, 32'h00000123);
    run_op(OP_MULTU, 32'h12345678, 32'h9ABCDEF0, 1'b0, lat1, bb, hb, hi1, lo1);
    run_op(OP_DIV, 32'hF0000001, 32'h00000123, 1'b0, lat2, bb, hb, hi2, lo2);
    total++; if ({hi1, lo1} !== e1) begin bad++; $display("FAIL b2b_first got=%h want=%h", {hi1, lo1}, e1); end
    total++; if (lat2 !== 34) begin bad++; $display("FAIL b2b_second_latency got=%0d want=34", lat2); end
    total++; if ({hi2, lo2} !== e2) begin bad++; $display("FAIL b2b_second got=%h want=%h", {hi2, lo2}, e2); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int seen, lat, bb, hb;
    logic [31:0] hi, lo;
    start = 1'b1; MDControl = OP_DIVU; SrcA = 32'hCAFEF00D; SrcB = 32'h00000013;
    @(negedge clk);
    start = 1'b0; MDControl = OP_NOP;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b want=0", busy); end
    total++; if (Hi !== 32'h0 || Lo !== 32'h0) begin bad++; $display("FAIL midreset_hilo got=%h/%h want=0/0", Hi, Lo); end
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (done !== 1'b0) seen++;
      @(negedge clk);
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL midreset_done done_cycles=%0d want=0", seen); end
    $display("reset mid-divu -> hi=%h lo=%h busy=%b", Hi, Lo, busy);
    run_op(OP_MULTU, 32'd3, 32'd5, 1'b0, lat, bb, hb, hi, lo);
    total++; if (lat !== 34) begin bad++; $display("FAIL postreset_latency got=%0d want=34", lat); end
    total++; if (hi !== 32'h0 || lo !== 32'h0000000F) begin bad++; $display("FAIL postreset_result got=%h/%h want=0/f", hi, lo); end
    @(negedge clk);
  endtask

  task automatic test_random();
    int lat, bb, hb;
    logic [31:0] hi, lo, a, b;
    logic [2:0]  op;
    logic [63:0] exp;
    logic [31:0] specials [6];
    specials = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h00000002};
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(1, 4));
      a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(8, 28);
      exp = ref_model(op, a, b);
      run_op(op, a, b, 1'b0, lat, bb, hb, hi, lo);
      total++; if (lat !== 34 || bb !== 0) begin bad++; $display("FAIL rand%0d_timing lat=%0d busy_gaps=%0d want=34/0", i, lat, bb); end
      total++; if ({hi, lo} !== exp) begin
        bad++; $display("FAIL rand%0d_result op=%0d a=%h b=%h got=%h want=%h", i, op, a, b, {hi, lo}, exp);
      end
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; MDControl = OP_NOP; SrcA = '0; SrcB = '0;
    test_reset();
    test_mul();
    test_div();
    test_mthilo();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_muldiv.md
Name: mips_muldiv

Overview:
- Execute-stage multiply/divide unit that owns the HI/LO register pair.
- Sits beside the ALU and takes the same SrcA/SrcB operands from register read/forwarding.
- Implements MULT, MULTU, DIV, DIVU, MTHI and MTLO. Hi/Lo feed the writeback mux for MFHI/MFLO.
- Multiply and divide are iterative (one bit per cycle). Control stalls the pipeline on busy.

Parameters:
- DATA_WIDTH, 32, operand and HI/LO width. The iteration count equals DATA_WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to execute MDControl this cycle.
- MDControl  input  3  operation select (encoding is in the package).
- SrcA  input  32  rs operand: multiplicand/dividend, or MTHI/MTLO data.
- SrcB  input  32  rt operand: multiplier/divisor.
- Hi  output  32  architectural HI register.
- Lo  output  32  architectural LO register.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when Hi/Lo take a new mul/div result.

Behaviour:
- One clock domain. Reset is synchronous and active-high on clk; reset has priority over every other input.
- Reset state: FSM=IDLE, Hi=0, Lo=0, busy=0, done=0, working registers cleared.
- MDControl encoding:
  - 000 NOP
  - 001 MULT
  - 010 MULTU
  - 011 DIV
  - 100 DIVU
  - 101 MTHI
  - 110 MTLO
  - 111 reserved, treated as NOP.
- FSM states: IDLE, CALC, FIX.
- IDLE & start & MDControl=MTHI: Hi<=SrcA at the next edge. No busy, no done.
- IDLE & start & MDControl=MTLO: Lo<=SrcA at the next edge. No busy, no done.
- IDLE & start & mul/div op (start seen in cycle N):
  - Latch the operand magnitudes (signed ops only), result-sign flags and op type.
  - Go to CALC with counter=0.
  - busy is high in cycles N+1..N+33.
- CALC: one radix-2 step per cycle for DATA_WIDTH cycles (counter 0..31), then go to FIX.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract producing a 32-bit quotient and 32-bit remainder.
- FIX (one cycle): apply signs, write Hi/Lo at the FIX edge, go to IDLE.
  - Signed multiply: negate the 64-bit product if the operand signs differ.
  - Signed divide: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - done=1 and busy=0 in cycle N+34. Total latency is 34 cycles from start to done.
- Hi/Lo hold their previous values throughout CALC. No intermediate values are visible.
- Result mapping: MULT/MULTU give {Hi,Lo}=64-bit product. DIV/DIVU give Lo=quotient and Hi=remainder.
- Divide by zero (signed or unsigned) is deterministic: Lo=32'hFFFFFFFF, Hi=SrcA as given. It takes the normal 34-cycle latency.
- Signed overflow 32'h80000000 / 32'hFFFFFFFF gives Lo=32'h80000000 and Hi=0.
- start while busy (any op, including MTHI/MTLO) is ignored with no side effects. The control stage must stall.
- start in the same cycle as the done pulse is accepted, because the FSM is already in IDLE.
- Reset mid-operation: the in-flight op is abandoned with no done pulse; Hi/Lo=0 and busy=0 after that edge.
- Operands are sampled only in the start cycle. Later changes on SrcA/SrcB have no effect on an in-flight op.

Decomposition:
- Package mips_muldiv_pkg holds:
  - the MDControl encoding as localparams/enum (MD_NOP, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO);
  - the FSM state enum (S_IDLE, S_CALC, S_FIX);
  - the DIVZERO_LO constant;
  - an is_muldiv() helper function.
- One sub-module, mips_muldiv_step: a combinational single-iteration datapath (shift-add or shift-subtract step selected by an is_div input). The top level holds the FSM, counter, working and HI/LO registers.

Test Plan:
- Reset, then MULT SrcA=FFFFFFFE, SrcB=00000003 -> busy for cycles N+1..N+33; done in N+34; Hi=FFFFFFFF, Lo=FFFFFFFA.
- MULTU FFFFFFFF*FFFFFFFF -> Hi=FFFFFFFE, Lo=00000001. Then MULT 80000000*80000000 -> Hi=40000000, Lo=00000000.
- DIV FFFFFFF9/00000002 -> Lo=FFFFFFFD, Hi=FFFFFFFF. DIVU 00000064/00000007 -> Lo=0000000E, Hi=00000002.
- DIV 00001234/0 -> Lo=FFFFFFFF, Hi=00001234 at N+34. DIV 80000000/FFFFFFFF -> Lo=80000000, Hi=00000000.
- MTLO A5A5A5A5 while idle -> Lo=A5A5A5A5 next cycle, done stays 0. MTHI and a second DIVU issued during busy -> ignored; Hi/Lo equal the first op's result only.
- DIVU issued, reset asserted at CALC counter=10 -> next cycle busy=0, Hi=Lo=0, done never pulses. A new MULTU 3*5 then gives Lo=0000000F after 34 cycles.
